// File: rtl/bin_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : bin_serializer
//  Purpose  : Buffers binary symbol words from the gray2bin chain in a small
//             FIFO and emits them as a 1-bit valid/ready stream, with a
//             sticky overflow flag for words dropped while the FIFO is full.
//  Revision : 1.0  initial release
// ============================================================================
module bin_serializer #(
    parameter int MODULATION_ORDER = 16,
    parameter int FIFO_DEPTH       = 4,
    parameter int MSB_FIRST        = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_dv,
    input  logic [$clog2(MODULATION_ORDER)-1:0] in_binary_code,
    output logic                                out_bit,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic [$clog2(FIFO_DEPTH):0]         level,
    output logic                                overflow,
    input  logic                                clr_overflow
);

    localparam int BITS    = $clog2(MODULATION_ORDER);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    // A 1-bit symbol still needs a 1-bit counter that simply stays at zero.
    localparam int c_cnt_w = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [BITS-1:0]       r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_lvl_w-1:0]    r_level;
    logic                  r_overflow;
    logic [BITS-1:0]       r_shift;
    logic [c_cnt_w-1:0]    r_cnt;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_last;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [BITS-1:0]       w_head;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_lvl_w'(FIFO_DEPTH));
    assign w_last  = (r_cnt == c_cnt_w'(BITS - 1));
    assign w_head  = r_mem[r_rd_ptr];

    // The shifter takes a new word whenever it is empty, or when its final bit
    // is being accepted; the latter keeps back-to-back symbols gap-free.
    assign w_pop  = !w_empty &&
                    ((r_state == ST_IDLE) || (out_ready && w_last));
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push = in_dv && (!w_full || w_pop);
    assign w_drop = in_dv && w_full && !w_pop;

    // FIFO storage: data only, no reset needed since pointers gate validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_binary_code;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
            // A drop in the same cycle as a clear wins, so no loss goes unseen.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Serialiser state machine: load, shift on handshake, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (out_ready) begin
                        if (w_last) begin
                            if (!w_empty) begin
                                r_shift <= w_head;
                                r_cnt   <= '0;
                            end else begin
                                // Clearing the shifter keeps out_bit at 0 while idle.
                                r_shift <= '0;
                                r_cnt   <= '0;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            if (MSB_FIRST != 0) begin
                                r_shift <= r_shift << 1;
                            end else begin
                                r_shift <= r_shift >> 1;
                            end
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_shift <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // The outgoing bit is the end of the shifter that bits leave from.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign out_bit = r_shift[BITS-1];
        end else begin : g_lsb_first
            assign out_bit = r_shift[0];
        end
    endgenerate

    assign out_valid = (r_state == ST_SHIFT);
    assign out_last  = (r_state == ST_SHIFT) && w_last;
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
